wb_target_mem: RTL and testbench

Wishbone classic-cycle target (responder) with an internal word-addressed RAM, a configurable wait-state count, byte-select writes and a completion counter. It is the far end of `WishboneInitiatorBFM` in smoke benches: the initiator BFM's `adr/dat_w/stb/cyc/we/sel` drive this block, and its `dat_r/ack/err` return to the BFM. It replaces the ad-hoc ack/loopback logic in bench top levels.

---
 rtl/wb_target_mem.sv | 206 ++++++++++++++++++++
 tb/tb_wb_target_mem.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_target_mem.sv
// wb_target_mem: Wishbone classic-cycle target with an internal word-addressed
// RAM, a fixed wait-state count, byte-select writes and a completion counter.
// Optional feature macro: WB_TARGET_MEM_ERR_EN. When defined, out-of-range
// accesses terminate with err. When undefined, err is tied low and addresses
// wrap modulo DEPTH_WORDS.
module wb_target_mem #(
    parameter int unsigned            ADDR_WIDTH  = 32,
    parameter int unsigned            DATA_WIDTH  = 32,
    parameter int unsigned            DEPTH_WORDS = 256,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = '0,
    parameter int unsigned            WAIT_STATES = 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [ADDR_WIDTH-1:0]     adr,
    input  logic [DATA_WIDTH-1:0]     dat_w,
    output logic [DATA_WIDTH-1:0]     dat_r,
    input  logic                      cyc,
    input  logic                      stb,
    input  logic                      we,
    input  logic [DATA_WIDTH/8-1:0]   sel,
    output logic                      ack,
    output logic                      err,
    output logic [15:0]               xfer_count
);

    localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned SHIFT     = $clog2(SEL_WIDTH);
    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              wait_cnt_q, wait_cnt_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic                    we_q, we_d;
    logic [SEL_WIDTH-1:0]    sel_q, sel_d;
    logic [DATA_WIDTH-1:0]   dat_w_q, dat_w_d;
    logic                    ack_q, ack_d;
    logic [DATA_WIDTH-1:0]   dat_r_q, dat_r_d;
    logic [15:0]             xfer_count_q, xfer_count_d;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH_WORDS];

    logic [ADDR_WIDTH-1:0]   req_adr;
    logic                    req_we;
    logic [SEL_WIDTH-1:0]    req_sel;
    logic [DATA_WIDTH-1:0]   req_dat_w;
    logic [IDX_W-1:0]        word_idx;
    logic                    resp_ok;
    logic                    enter_resp;
    logic                    mem_we;

`ifdef WB_TARGET_MEM_ERR_EN
    logic                    err_q, err_d;
`endif

    // Request fields: live bus in IDLE (zero-wait path), latched copy otherwise
    always_comb begin
        req_adr   = adr_q;
        req_we    = we_q;
        req_sel   = sel_q;
        req_dat_w = dat_w_q;
        if (state_q == ST_IDLE) begin
            req_adr   = adr;
            req_we    = we;
            req_sel   = sel;
            req_dat_w = dat_w;
        end
        word_idx = IDX_W'((req_adr - BASE_ADDR) >> SHIFT);
`ifdef WB_TARGET_MEM_ERR_EN
        resp_ok = (req_adr >= BASE_ADDR) &&
                  (((req_adr - BASE_ADDR) >> SHIFT) < ADDR_WIDTH'(DEPTH_WORDS));
`else
        resp_ok = 1'b1;
`endif
    end

    // Next-state, termination, read data and completion counter
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        adr_d        = adr_q;
        we_d         = we_q;
        sel_d        = sel_q;
        dat_w_d      = dat_w_q;
        ack_d        = 1'b0;
        dat_r_d      = '0;
        xfer_count_d = xfer_count_q;
        enter_resp   = 1'b0;
        mem_we       = 1'b0;
`ifdef WB_TARGET_MEM_ERR_EN
        err_d        = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (cyc && stb) begin
                    adr_d   = adr;
                    we_d    = we;
                    sel_d   = sel;
                    dat_w_d = dat_w;
                    if (WAIT_STATES == 0) begin
                        enter_resp = 1'b1;
                    end else begin
                        wait_cnt_d = 4'(WAIT_STATES);
                        state_d    = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!(cyc && stb)) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == 4'd1) begin
                    enter_resp = 1'b1;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Write and read data both take effect on the edge entering RESP
        if (enter_resp) begin
            state_d = ST_RESP;
            if (resp_ok) begin
                ack_d  = 1'b1;
                mem_we = req_we;
                if (!req_we) begin
                    dat_r_d = mem_q[word_idx];
                end
            end else begin
`ifdef WB_TARGET_MEM_ERR_EN
                err_d = 1'b1;
`endif
            end
        end

        if (ack_q) begin
            xfer_count_d = xfer_count_q + 16'd1;
        end
    end

    // Control and output registers with asynchronous reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            wait_cnt_q   <= '0;
            adr_q        <= '0;
            we_q         <= 1'b0;
            sel_q        <= '0;
            dat_w_q      <= '0;
            ack_q        <= 1'b0;
            dat_r_q      <= '0;
            xfer_count_q <= '0;
`ifdef WB_TARGET_MEM_ERR_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            adr_q        <= adr_d;
            we_q         <= we_d;
            sel_q        <= sel_d;
            dat_w_q      <= dat_w_d;
            ack_q        <= ack_d;
            dat_r_q      <= dat_r_d;
            xfer_count_q <= xfer_count_d;
`ifdef WB_TARGET_MEM_ERR_EN
            err_q        <= err_d;
`endif
        end
    end

    // RAM byte-lane writes; contents are not reset
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < SEL_WIDTH; i++) begin
                if (req_sel[i]) begin
                    mem_q[word_idx][8*i +: 8] <= req_dat_w[8*i +: 8];
                end
            end
        end
    end

    assign ack        = ack_q;
    assign dat_r      = dat_r_q;
    assign xfer_count = xfer_count_q;
`ifdef WB_TARGET_MEM_ERR_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_wb_target_mem.sv
// tb_wb_target_mem: three wb_target_mem instances (wait states 0, 1, 3) driven
// one at a time by a simple initiator and checked against a behavioural model
// of the RAM, the termination rules and the completion counter.
module tb_wb_target_mem;

    localparam int NI = 3;

    logic                 clock;
    logic                 reset_n;
    logic [NI-1:0][31:0]  adr;
    logic [NI-1:0][31:0]  dat_w;
    logic [NI-1:0][31:0]  dat_r;
    logic [NI-1:0]        cyc;
    logic [NI-1:0]        stb;
    logic [NI-1:0]        we;
    logic [NI-1:0][3:0]   sel;
    logic [NI-1:0]        ack;
    logic [NI-1:0]        err;
    logic [NI-1:0][15:0]  xfer_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] mem_m [NI][256];
    logic [15:0] cnt_m [NI];

    wb_target_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(256),
                    .BASE_ADDR(32'h1000), .WAIT_STATES(0)) u_dut0 (
        .clock(clock), .reset_n(reset_n), .adr(adr[0]), .dat_w(dat_w[0]),
        .dat_r(dat_r[0]), .cyc(cyc[0]), .stb(stb[0]), .we(we[0]), .sel(sel[0]),
        .ack(ack[0]), .err(err[0]), .xfer_count(xfer_count[0]));

    wb_target_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(256),
                    .BASE_ADDR(32'h0), .WAIT_STATES(1)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .adr(adr[1]), .dat_w(dat_w[1]),
        .dat_r(dat_r[1]), .cyc(cyc[1]), .stb(stb[1]), .we(we[1]), .sel(sel[1]),
        .ack(ack[1]), .err(err[1]), .xfer_count(xfer_count[1]));

    wb_target_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(256),
                    .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_dut2 (
        .clock(clock), .reset_n(reset_n), .adr(adr[2]), .dat_w(dat_w[2]),
        .dat_r(dat_r[2]), .cyc(cyc[2]), .stb(stb[2]), .we(we[2]), .sel(sel[2]),
        .ack(ack[2]), .err(err[2]), .xfer_count(xfer_count[2]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] base_of(input int k);
        return (k == 0) ? 32'h1000 : 32'h0;
    endfunction

    function automatic int ws_of(input int k);
        case (k)
            0:       return 0;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic logic in_rng(input int k, input logic [31:0] a);
        logic [31:0] off;
        off = a - base_of(k);
        return (a >= base_of(k)) && ((off / 4) < 256);
    endfunction

    function automatic int idx_of(input int k, input logic [31:0] a);
        logic [31:0] off;
        off = a - base_of(k);
        return int'((off / 4) % 256);
    endfunction

    function automatic logic exp_err(input int k, input logic [31:0] a);
`ifdef WB_TARGET_MEM_ERR_EN
        return !in_rng(k, a);
`else
        return (a == 32'hFFFF_FFFF) && (k < 0);
`endif
    endfunction

    // One complete transfer; called just after a falling edge with the bus idle
    task automatic xfer(input int k, input logic [31:0] a, input logic w,
                        input logic [31:0] d, input logic [3:0] s, output logic [31:0] rd);
        int  n;
        logic done;
        logic e;
        int  ix;
        n = 0;
        done = 1'b0;
        e = exp_err(k, a);
        ix = idx_of(k, a);
        rd = '0;
        adr[k] = a; dat_w[k] = d; we[k] = w; sel[k] = s;
        cyc[k] = 1'b1; stb[k] = 1'b1;
        @(posedge clock);
        while (!done && n < 40) begin
            @(negedge clock);
            n++;
            if (ack[k] || err[k]) done = 1'b1;
            else @(posedge clock);
        end
        check("terminated", {31'b0, done}, 32'd1);
        if (done) begin
            check("latency", n, ws_of(k) + 1);
            check("term_ack_err", {30'b0, ack[k], err[k]}, e ? 32'd1 : 32'd2);
            rd = dat_r[k];
            if (e) begin
                check("err_dat_r", dat_r[k], 32'h0);
            end else begin
                if (!w) check("rdata", dat_r[k], mem_m[k][ix]);
                cnt_m[k] = cnt_m[k] + 16'd1;
            end
            if (w && !e) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) mem_m[k][ix][8*b +: 8] = d[8*b +: 8];
            end
        end
        cyc[k] = 1'b0; stb[k] = 1'b0;
        @(negedge clock);
        check("one_cycle_term", {30'b0, ack[k], err[k]}, 32'd0);
        check("dat_r_idle", dat_r[k], 32'h0);
    endtask

    // Held read request: acks must arrive every WAIT_STATES+2 cycles
    task automatic b2b(input int k, input logic [31:0] a, input int nacks);
        int last;
        int got;
        last = -1;
        got = 0;
        adr[k] = a; we[k] = 1'b0; sel[k] = 4'hF; dat_w[k] = '0;
        cyc[k] = 1'b1; stb[k] = 1'b1;
        for (int c = 0; c < nacks * 20 && got < nacks; c++) begin
            @(negedge clock);
            if (ack[k]) begin
                if (last >= 0) check("b2b_period", c - last, ws_of(k) + 2);
                check("b2b_rdata", dat_r[k], mem_m[k][idx_of(k, a)]);
                last = c;
                got++;
                cnt_m[k] = cnt_m[k] + 16'd1;
            end
        end
        cyc[k] = 1'b0; stb[k] = 1'b0;
        check("b2b_count", got, nacks);
        @(negedge clock);
    endtask

    function automatic logic [31:0] rand_adr(input int k);
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return base_of(k) + 32'h400 + 32'($urandom_range(0, 1023)) * 4;
        if (r == 1 && base_of(k) != 0) return base_of(k) - 32'($urandom_range(1, 16)) * 4;
        return base_of(k) + 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(0, 3));
    endfunction

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic        seen;

        reset_n = 1'b0;
        adr = '0; dat_w = '0; cyc = '0; stb = '0; we = '0; sel = '0;
        for (int k = 0; k < NI; k++) cnt_m[k] = '0;
        #1;
        for (int k = 0; k < NI; k++) begin
            check("rst_ack", {31'b0, ack[k]}, 32'd0);
            check("rst_err", {31'b0, err[k]}, 32'd0);
            check("rst_dat_r", dat_r[k], 32'h0);
            check("rst_count", {16'b0, xfer_count[k]}, 32'd0);
        end
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        // Write/read and byte-select on the single-wait-state instance
        xfer(1, 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, rd);
        xfer(1, 32'h10, 1'b0, 32'h0, 4'hF, rd);
        check("rd_deadbeef", rd, 32'hDEADBEEF);
        check("count_after_two", {16'b0, xfer_count[1]}, {16'b0, cnt_m[1]});
        xfer(1, 32'h20, 1'b1, 32'h11223344, 4'hF, rd);
        xfer(1, 32'h20, 1'b1, 32'hAABBCCDD, 4'h5, rd);
        xfer(1, 32'h20, 1'b0, 32'h0, 4'hF, rd);
        check("byte_select", rd, 32'h11BB33DD);

        // Fill every word of every instance so later reads are defined
        for (int k = 0; k < NI; k++)
            for (int i = 0; i < 256; i++)
                xfer(k, base_of(k) + 32'(i) * 4, 1'b1, $urandom, 4'hF, rd);
        for (int k = 0; k < NI; k++)
            check("count_after_fill", {16'b0, xfer_count[k]}, {16'b0, cnt_m[k]});

        for (int k = 0; k < NI; k++) b2b(k, base_of(k) + 32'h40, 4);

        // Abort: drop cyc one cycle into the wait sequence
        xfer(2, 32'h14, 1'b1, 32'h01020304, 4'hF, rd);
        adr[2] = 32'h14; dat_w[2] = 32'hFFFF0000; we[2] = 1'b1; sel[2] = 4'hF;
        cyc[2] = 1'b1; stb[2] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cyc[2] = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clock);
            seen = seen | ack[2] | err[2];
        end
        stb[2] = 1'b0;
        check("abort_no_term", {31'b0, seen}, 32'd0);
        check("abort_count", {16'b0, xfer_count[2]}, {16'b0, cnt_m[2]});
        xfer(2, 32'h14, 1'b0, 32'h0, 4'hF, rd);
        check("abort_ram", rd, 32'h01020304);

        // Out of range write: err (no write) or wrap onto word 0
        xfer(1, 32'h0, 1'b1, 32'h55AA55AA, 4'hF, rd);
        xfer(1, 32'h400, 1'b1, 32'h12345678, 4'hF, rd);
        xfer(1, 32'h0, 1'b0, 32'h0, 4'hF, rd);
        check("oor_word0", rd, mem_m[1][0]);

        // Randomised traffic on all instances
        for (int k = 0; k < NI; k++) begin
            for (int t = 0; t < 60; t++) begin
                a = rand_adr(k);
                xfer(k, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), rd);
            end
            check("count_after_rand", {16'b0, xfer_count[k]}, {16'b0, cnt_m[k]});
        end

        // Reset during WAIT
        adr[2] = 32'h20; we[2] = 1'b0; sel[2] = 4'hF;
        cyc[2] = 1'b1; stb[2] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            check("midrst_ack", {31'b0, ack[k]}, 32'd0);
            check("midrst_err", {31'b0, err[k]}, 32'd0);
            check("midrst_count", {16'b0, xfer_count[k]}, 32'd0);
            cnt_m[k] = '0;
        end
        cyc[2] = 1'b0; stb[2] = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clock);
            seen = seen | ack[2] | err[2];
        end
        check("no_ack_after_rst", {31'b0, seen}, 32'd0);
        xfer(2, 32'h14, 1'b0, 32'h0, 4'hF, rd);
        check("ram_kept_over_rst", rd, 32'h01020304);
        check("count_after_rst", {16'b0, xfer_count[2]}, {16'b0, cnt_m[2]});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
